ascon_out_serializer: RTL and testbench
=======================================

// Module: ascon_out_serializer
// PURPOSE
//  Output-side companion of the ASCON AEAD core (processing): when the core raises encryption_r or
//  decryption_r, captures the parallel result (ciphertext/tag or dec_plaintext/dec_tag/msg_auth)
//  and streams it out bit-serially, MSB first, on the text_SO/tag_SO pins under a valid/ready
//  handshake. Sits between the core and the pin-limited serial export port (the *_SO lines).
// PARAMETERS
//  text_l  128  width of ciphertext / dec_plaintext in bits (>=1)
//  tag_l   128  width of tag / dec_tag in bits (>=1)
// PORTS
//  clk            in   1       single clock; all logic on posedge clk
//  rst            in   1       synchronous, active-high reset
//  encryption_r   in   1       core encryption-done level; rising edge triggers capture
//  decryption_r   in   1       core decryption-done level; rising edge triggers capture
//  ciphertext     in   text_l  encryption result
//  tag            in   tag_l   encryption tag
//  dec_plaintext  in   text_l  decryption result
//  dec_tag        in   tag_l   recomputed tag on decryption
//  msg_auth       in   1       core authentication verdict
//  sink_ready     in   1       receiver accepts current bit this cycle
//  so_valid       out  1       text_SO/tag_SO carry a valid bit
//  text_SO        out  1       serial text bit, MSB first
//  tag_SO         out  1       serial tag bit, MSB first
//  so_last        out  1       current bit is the final bit of the frame
//  mode_SO        out  1       0 = encryption frame, 1 = decryption frame (held for whole frame)
//  auth_SO        out  1       captured msg_auth (decryption frames), 0 for encryption frames
//  busy           out  1       frame captured and not yet fully shifted
//  done           out  1       one-cycle pulse after the last bit is accepted
//  overrun        out  1       sticky: a trigger edge was dropped
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, counter 0, shift registers 0; edge-detect history regs
//    load 1 so a level already high across reset does NOT trigger.
//  - Edge detect: trig_e = encryption_r & ~enc_q; trig_d = decryption_r & ~dec_q (regs update every cycle).
//  - FSM IDLE: on trig_e load {ciphertext,tag}, mode_SO=0, auth_SO=0; else on trig_d load
//    {dec_plaintext,dec_tag}, mode_SO=1, auth_SO=msg_auth; -> SHIFT. Same-cycle trig_e&trig_d:
//    encryption wins, overrun<=1.
//  - SHIFT: so_valid=1, busy=1. Frame length L = max(text_l,tag_l) bits; cnt counts 0..L-1.
//    Shorter field is left-aligned MSB-first and emits 0 after its own width is exhausted.
//    Bit advances only when so_valid & sink_ready; outputs hold stable while sink_ready=0.
//    so_last=1 when cnt==L-1. Accept at cnt==L-1 -> DONE.
//  - DONE: so_valid=0, busy=0, done=1 for exactly one cycle -> IDLE.
//  - Latency: trigger edge sampled at edge N -> first bit valid after edge N, visible in cycle N+1;
//    with sink_ready tied high, done asserted in cycle N+1+L.
//  - Any trigger edge in SHIFT or DONE is dropped and sets overrun; frame in progress unaffected.
//    overrun clears only on rst.
//  - rst asserted mid-frame: frame abandoned immediately, reset values apply next cycle, no done.
//  - Counter width $clog2(L)+1; no wrap-around within a frame.
// STRUCTURE
//  - Shared package ascon_pkg: FSM state enum {IDLE,SHIFT,DONE}, MODE_ENC=1'b0/MODE_DEC=1'b1,
//    default TEXT_L=128/TAG_L=128 constants.
//  - One sub-module: ascon_piso #(W) (load, shift enable, serial MSB out, zero fill), instanced
//    for text and tag; FSM, counter, edge detect and flags in the top.
// TESTING
//  1 Enc frame: ciphertext=128'h2e325340df7fd0bfd25bec2d8a596b44, tag=128'h526e4b15b4b3184a2fc1f7d160e4e972,
//    pulse encryption_r, sink_ready=1 -> 128 bits reassemble to same values, mode_SO=0,
//    so_last on bit 128, done exactly 129 cycles after trigger.
//  2 Dec frame: same values on dec_*, msg_auth=1 -> identical streams, mode_SO=1, auth_SO=1.
//  3 Backpressure: sink_ready random 50% -> bit stream unchanged, outputs stable while stalled,
//    done only after 128th accept.
//  4 Unequal widths text_l=112, tag_l=128, text=112'h000102030405060708090a0b0c0d ->
//    text_SO last 16 bits 0, L=128.
//  5 Collision: encryption_r & decryption_r rise same cycle -> enc frame sent, overrun=1;
//    second encryption_r edge mid-frame -> ignored, overrun stays 1.
//  6 Reset: rst at bit 40 -> next cycle so_valid=0, busy=0, no done; encryption_r held high
//    through reset -> no spurious frame.

Source files
------------

// File: rtl/ascon_pkg.sv
// ----------------------------------------------------------------------------
// ascon_pkg
// Shared definitions for the ASCON output serializer slice: the serializer
// FSM state encoding, the frame-mode encoding driven on mode_SO, default
// field widths and a small width helper.
// ----------------------------------------------------------------------------
package ascon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int TEXT_L = 128;
    localparam int TAG_L  = 128;

    // Frame length: the longer of the two fields sets the number of bit slots.
    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ascon_piso.sv
// ----------------------------------------------------------------------------
// ascon_piso
// Parallel-in / serial-out shift register, MSB first. Zeros are shifted in at
// the bottom, so once W bits have left the register the serial output reads 0;
// this gives the zero fill for a field shorter than the frame.
// Ports:
//   clk      in  1  clock
//   rst      in  1  synchronous active-high reset (clears the register)
//   load     in  1  capture din (takes priority over shift_en)
//   shift_en in  1  advance one bit toward the MSB
//   din      in  W  parallel data to capture
//   sout     out 1  current serial bit (register MSB)
// ----------------------------------------------------------------------------
module ascon_piso #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] sreg_r;

    // Shift register: load, shift with zero fill, or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_r <= '0;
        end else if (load) begin
            sreg_r <= din;
        end else if (shift_en) begin
            sreg_r <= sreg_r << 1'b1;
        end else begin
            sreg_r <= sreg_r;
        end
    end

    assign sout = sreg_r[W-1];

endmodule

// File: rtl/ascon_out_serializer.sv
// ----------------------------------------------------------------------------
// ascon_out_serializer
// Captures the ASCON core result on a rising edge of encryption_r or
// decryption_r and streams text and tag bit-serially (MSB first) under a
// valid/ready handshake. Every output is a flop.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   encryption_r, decryption_r   core done levels; rising edge starts a frame
//   ciphertext, tag              encryption result / tag
//   dec_plaintext, dec_tag       decryption result / recomputed tag
//   msg_auth                     core authentication verdict
//   sink_ready                   receiver accepts the current bit
//   so_valid, text_SO, tag_SO    serial bit pair and its valid
//   so_last                      current bit is the final one of the frame
//   mode_SO, auth_SO             frame mode (0 enc / 1 dec), captured verdict
//   busy, done, overrun          frame active, end pulse, sticky dropped trigger
// ----------------------------------------------------------------------------
module ascon_out_serializer
    import ascon_pkg::*;
#(
    parameter int text_l = TEXT_L,
    parameter int tag_l  = TAG_L
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              encryption_r,
    input  logic              decryption_r,
    input  logic [text_l-1:0] ciphertext,
    input  logic [tag_l-1:0]  tag,
    input  logic [text_l-1:0] dec_plaintext,
    input  logic [tag_l-1:0]  dec_tag,
    input  logic              msg_auth,
    input  logic              sink_ready,
    output logic              so_valid,
    output logic              text_SO,
    output logic              tag_SO,
    output logic              so_last,
    output logic              mode_SO,
    output logic              auth_SO,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int L  = max_len(text_l, tag_l);
    localparam int CW = $clog2(L) + 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    state_e          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            enc_q_r, dec_q_r;
    logic            so_valid_r, so_last_r, mode_r, auth_r, busy_r, done_r, overrun_r;
    logic            mode_s, auth_s, done_s, overrun_s;
    logic            trig_e_s, trig_d_s, accept_s;
    logic            load_s, load_e_s, shift_s;
    logic [text_l-1:0] text_din_s;
    logic [tag_l-1:0]  tag_din_s;

    assign trig_e_s = encryption_r & ~enc_q_r;
    assign trig_d_s = decryption_r & ~dec_q_r;
    assign accept_s = so_valid_r & sink_ready;

    // Edge-detect history; reset loads 1 so a level held high across reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_q_r <= 1'b1;
            dec_q_r <= 1'b1;
        end else begin
            enc_q_r <= encryption_r;
            dec_q_r <= decryption_r;
        end
    end

    // Next-state, counter, capture and flag logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        mode_s    = mode_r;
        auth_s    = auth_r;
        overrun_s = overrun_r;
        done_s    = 1'b0;
        load_s    = 1'b0;
        load_e_s  = 1'b0;
        shift_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (trig_e_s) begin
                    // Encryption wins a same-cycle collision; the decryption edge is lost.
                    load_s    = 1'b1;
                    load_e_s  = 1'b1;
                    mode_s    = MODE_ENC;
                    auth_s    = 1'b0;
                    cnt_s     = '0;
                    state_s   = SHIFT;
                    overrun_s = overrun_r | trig_d_s;
                end else if (trig_d_s) begin
                    load_s  = 1'b1;
                    mode_s  = MODE_DEC;
                    auth_s  = msg_auth;
                    cnt_s   = '0;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                overrun_s = overrun_r | trig_e_s | trig_d_s;
                if (accept_s) begin
                    shift_s = 1'b1;
                    if (cnt_r == LAST) begin
                        cnt_s   = '0;
                        done_s  = 1'b1;
                        state_s = DONE;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    shift_s = 1'b0;
                end
            end
            DONE: begin
                overrun_s = overrun_r | trig_e_s | trig_d_s;
                state_s   = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Capture source select for the two shift registers.
    always_comb begin
        text_din_s = dec_plaintext;
        tag_din_s  = dec_tag;
        if (load_e_s) begin
            text_din_s = ciphertext;
            tag_din_s  = tag;
        end else begin
            text_din_s = dec_plaintext;
            tag_din_s  = dec_tag;
        end
    end

    // State, counter and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            so_valid_r <= 1'b0;
            so_last_r  <= 1'b0;
            busy_r     <= 1'b0;
            mode_r     <= 1'b0;
            auth_r     <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            so_valid_r <= (state_s == SHIFT);
            busy_r     <= (state_s == SHIFT);
            so_last_r  <= (state_s == SHIFT) && (cnt_s == LAST);
            mode_r     <= mode_s;
            auth_r     <= auth_s;
            done_r     <= done_s;
            overrun_r  <= overrun_s;
        end
    end

    ascon_piso #(.W(text_l)) u_text_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .shift_en (shift_s),
        .din      (text_din_s),
        .sout     (text_SO)
    );

    ascon_piso #(.W(tag_l)) u_tag_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .shift_en (shift_s),
        .din      (tag_din_s),
        .sout     (tag_SO)
    );

    assign so_valid = so_valid_r;
    assign so_last  = so_last_r;
    assign mode_SO  = mode_r;
    assign auth_SO  = auth_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_ascon_out_serializer.sv
// ----------------------------------------------------------------------------
// tb_ascon_out_serializer
// Two instances: dut_a (128/128) and dut_b (112-bit text, 128-bit tag) share
// control inputs. Received bits are reassembled into words and compared with
// the left-aligned, zero-filled values the frame should carry.
// ----------------------------------------------------------------------------
module tb_ascon_out_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         encryption_r = 1'b0;
    logic         decryption_r = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] tag = '0;
    logic [127:0] dec_plaintext = '0;
    logic [127:0] dec_tag = '0;
    logic [111:0] text_b = '0;
    logic [111:0] dec_b = '0;
    logic         msg_auth = 1'b0;
    logic         sink_ready = 1'b0;

    logic va, ta, ga, la, ma, aa, ba, da, oa;
    logic vb, tb, gb, lb, mb, ab, bb, db, ob;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ascon_out_serializer #(.text_l(128), .tag_l(128)) dut_a (
        .clk(clk), .rst(rst), .encryption_r(encryption_r), .decryption_r(decryption_r),
        .ciphertext(ciphertext), .tag(tag), .dec_plaintext(dec_plaintext), .dec_tag(dec_tag),
        .msg_auth(msg_auth), .sink_ready(sink_ready), .so_valid(va), .text_SO(ta), .tag_SO(ga),
        .so_last(la), .mode_SO(ma), .auth_SO(aa), .busy(ba), .done(da), .overrun(oa)
    );

    ascon_out_serializer #(.text_l(112), .tag_l(128)) dut_b (
        .clk(clk), .rst(rst), .encryption_r(encryption_r), .decryption_r(decryption_r),
        .ciphertext(text_b), .tag(tag), .dec_plaintext(dec_b), .dec_tag(dec_tag),
        .msg_auth(msg_auth), .sink_ready(sink_ready), .so_valid(vb), .text_SO(tb), .tag_SO(gb),
        .so_last(lb), .mode_SO(mb), .auth_SO(ab), .busy(bb), .done(db), .overrun(ob)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tg, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    task automatic sample(input bit sel, output logic v, output logic t, output logic g,
                          output logic l, output logic m, output logic a, output logic b,
                          output logic d);
        if (sel) begin
            v = vb; t = tb; g = gb; l = lb; m = mb; a = ab; b = bb; d = db;
        end else begin
            v = va; t = ta; g = ga; l = la; m = ma; a = aa; b = ba; d = da;
        end
    endtask

    // Caller has already driven the trigger level; the first tick here is edge N.
    // done_cyc: cycles after edge N at which done was seen; -1 timeout,
    // -2 done at the wrong moment, -3 done longer than one cycle.
    task automatic run_frame(input bit sel, input bit rnd, input int poke, input int abort_at,
                             input bit drop_trig,
                             output logic [127:0] trx, output logic [127:0] grx,
                             output bit last_ok, output bit stable_ok, output int done_cyc,
                             output logic mode0, output logic auth0);
        logic v, t, g, l, m, a, b, d;
        logic [4:0] snap;
        bit stalled, fin, rdy;
        int nb, cyc, last_acc;
        trx = '0; grx = '0; last_ok = 1'b1; stable_ok = 1'b1; done_cyc = -1;
        mode0 = 1'b0; auth0 = 1'b0; snap = '0; stalled = 1'b0; fin = 1'b0;
        nb = 0; cyc = 1; last_acc = -10;
        tick();
        while (!fin && cyc <= 600) begin
            sample(sel, v, t, g, l, m, a, b, d);
            if (cyc == poke) begin
                encryption_r = 1'b1;
            end else if (drop_trig) begin
                encryption_r = 1'b0;
                decryption_r = 1'b0;
            end
            if (cyc == 1) begin
                mode0 = m;
                auth0 = a;
            end
            if (stalled && (v !== 1'b1 || {t, g, l, m, a} !== snap)) stable_ok = 1'b0;
            if (v !== b) stable_ok = 1'b0;
            if (abort_at >= 0 && nb == abort_at) begin
                rst = 1'b1;
                tick();
                return;
            end
            if (d === 1'b1) begin
                done_cyc = (nb == 128 && cyc == last_acc + 1) ? cyc : -2;
                fin = 1'b1;
            end else begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                sink_ready = rdy;
                if (v === 1'b1 && rdy) begin
                    if (nb < 128) begin
                        trx[127-nb] = t;
                        grx[127-nb] = g;
                        if (l !== (nb == 127)) last_ok = 1'b0;
                    end else begin
                        last_ok = 1'b0;
                    end
                    nb++;
                    last_acc = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = (v === 1'b1);
                    snap = {t, g, l, m, a};
                end
                tick();
                cyc++;
            end
        end
        if (fin) begin
            tick();
            sample(sel, v, t, g, l, m, a, b, d);
            if (d !== 1'b0 || v !== 1'b0 || b !== 1'b0) done_cyc = -3;
        end
    endtask

    logic [127:0] trx, grx, ect, etg;
    logic         m0, a0, exp_mode, exp_auth;
    bit           lok, sok, flag;
    int           dcyc;

    initial begin
        // Reset state, including an idle period after release.
        rst = 1'b1;
        tick(); tick(); tick();
        chk("reset_outs", 128'({va, ta, ga, la, ma, aa, ba, da, oa}), 128'd0);
        rst = 1'b0;
        tick(); tick();
        chk("idle_outs", 128'({va, ta, ga, la, ma, aa, ba, da, oa}), 128'd0);

        // 1: encryption frame, sink always ready.
        ciphertext = 128'h2e325340df7fd0bfd25bec2d8a596b44;
        tag        = 128'h526e4b15b4b3184a2fc1f7d160e4e972;
        encryption_r = 1'b1;
        run_frame(1'b0, 1'b0, -1, -1, 1'b1, trx, grx, lok, sok, dcyc, m0, a0);
        chk("t1_text", trx, ciphertext);
        chk("t1_tag", grx, tag);
        chk("t1_mode", 128'(m0), 128'd0);
        chk("t1_auth", 128'(a0), 128'd0);
        chk("t1_last", 128'(lok), 128'd1);
        chk("t1_busy", 128'(sok), 128'd1);
        chk("t1_done_cyc", 128'(dcyc), 128'd129);

        // 2: decryption frame with the same values, verdict 1.
        dec_plaintext = ciphertext;
        dec_tag       = tag;
        msg_auth      = 1'b1;
        decryption_r  = 1'b1;
        run_frame(1'b0, 1'b0, -1, -1, 1'b1, trx, grx, lok, sok, dcyc, m0, a0);
        chk("t2_text", trx, ciphertext);
        chk("t2_tag", grx, tag);
        chk("t2_mode", 128'(m0), 128'd1);
        chk("t2_auth", 128'(a0), 128'd1);
        chk("t2_done_cyc", 128'(dcyc), 128'd129);

        // 3: random data, random mode and verdict, random backpressure.
        for (int k = 0; k < 3; k++) begin
            ciphertext    = {$urandom, $urandom, $urandom, $urandom};
            tag           = {$urandom, $urandom, $urandom, $urandom};
            dec_plaintext = {$urandom, $urandom, $urandom, $urandom};
            dec_tag       = {$urandom, $urandom, $urandom, $urandom};
            msg_auth      = 1'($urandom_range(0, 1));
            exp_mode      = 1'($urandom_range(0, 1));
            exp_auth      = exp_mode & msg_auth;
            ect           = exp_mode ? dec_plaintext : ciphertext;
            etg           = exp_mode ? dec_tag : tag;
            if (exp_mode) decryption_r = 1'b1;
            else          encryption_r = 1'b1;
            run_frame(1'b0, 1'b1, -1, -1, 1'b1, trx, grx, lok, sok, dcyc, m0, a0);
            chk($sformatf("t3_%0d_text", k), trx, ect);
            chk($sformatf("t3_%0d_tag", k), grx, etg);
            chk($sformatf("t3_%0d_mode", k), 128'(m0), 128'(exp_mode));
            chk($sformatf("t3_%0d_auth", k), 128'(a0), 128'(exp_auth));
            chk($sformatf("t3_%0d_last", k), 128'(lok), 128'd1);
            chk($sformatf("t3_%0d_stable", k), 128'(sok), 128'd1);
            chk($sformatf("t3_%0d_done_ok", k), 128'(dcyc >= 129), 128'd1);
        end

        // 4: unequal widths on dut_b, 112-bit text zero-filled to 128 slots.
        text_b = 112'h000102030405060708090a0b0c0d;
        tag    = 128'h526e4b15b4b3184a2fc1f7d160e4e972;
        encryption_r = 1'b1;
        run_frame(1'b1, 1'b0, -1, -1, 1'b1, trx, grx, lok, sok, dcyc, m0, a0);
        chk("t4_text", trx, {text_b, 16'h0000});
        chk("t4_text_tail", 128'(trx[15:0]), 128'd0);
        chk("t4_tag", grx, tag);
        chk("t4_last", 128'(lok), 128'd1);
        chk("t4_done_cyc", 128'(dcyc), 128'd129);

        // 5a: second encryption edge mid-frame is dropped and flagged.
        chk("t5_overrun_pre", 128'(oa), 128'd0);
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        tag        = {$urandom, $urandom, $urandom, $urandom};
        encryption_r = 1'b1;
        run_frame(1'b0, 1'b0, 30, -1, 1'b1, trx, grx, lok, sok, dcyc, m0, a0);
        chk("t5_poke_text", trx, ciphertext);
        chk("t5_poke_tag", grx, tag);
        chk("t5_poke_done_cyc", 128'(dcyc), 128'd129);
        chk("t5_poke_overrun", 128'(oa), 128'd1);

        // 6: reset after 40 bits, encryption_r held high through reset.
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        encryption_r = 1'b1;
        run_frame(1'b0, 1'b0, -1, 40, 1'b0, trx, grx, lok, sok, dcyc, m0, a0);
        chk("t6_rst_outs", 128'({va, ba, da, oa}), 128'd0);
        rst = 1'b0;
        flag = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (va !== 1'b0 || da !== 1'b0 || ba !== 1'b0) flag = 1'b1;
        end
        chk("t6_no_spurious", 128'(flag), 128'd0);
        encryption_r = 1'b0;
        tick();

        // 5b: simultaneous edges -> encryption frame, overrun set.
        ciphertext    = {$urandom, $urandom, $urandom, $urandom};
        tag           = {$urandom, $urandom, $urandom, $urandom};
        dec_plaintext = ~ciphertext;
        dec_tag       = ~tag;
        msg_auth      = 1'b1;
        encryption_r  = 1'b1;
        decryption_r  = 1'b1;
        run_frame(1'b0, 1'b0, -1, -1, 1'b1, trx, grx, lok, sok, dcyc, m0, a0);
        chk("t5_coll_text", trx, ciphertext);
        chk("t5_coll_tag", grx, tag);
        chk("t5_coll_mode", 128'(m0), 128'd0);
        chk("t5_coll_auth", 128'(a0), 128'd0);
        chk("t5_coll_overrun", 128'(oa), 128'd1);
        chk("t5_coll_done_cyc", 128'(dcyc), 128'd129);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
